// File: rtl/writeback_stage_pkg.sv
// -----------------------------------------------------------------------------
// writeback_stage_pkg
// Shared definitions for the writeback stage and its load-align helper.
//   LOAD_*      : encodings of the load-size field (2'b11 also decodes as word)
//   REG_IDX_W   : register index width
//   DATA_W      : datapath width
//   wb_entry_t  : one pending register-file write {rd, data}
// -----------------------------------------------------------------------------
package writeback_stage_pkg;

    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 32;

    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// -----------------------------------------------------------------------------
// wb_load_align
// Purely combinational load-data extraction from a big-endian memory word.
// Byte offset 0 lives in in_mem[31:24]. Sub-word results are sign- or
// zero-extended according to in_signed; word loads pass through unchanged.
// Ports:
//   in_mem      (in, 32) : memory word
//   in_addr_lo  (in, 2)  : low address bits of the load
//   in_size     (in, 2)  : 00 byte, 01 halfword, 10/11 word
//   in_signed   (in, 1)  : 1 sign-extends sub-word loads
//   load_data_o (out,32) : extracted, extended data
// -----------------------------------------------------------------------------
module wb_load_align
    import writeback_stage_pkg::*;
(
    input  logic [DATA_W-1:0] in_mem,
    input  logic [1:0]        in_addr_lo,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    output logic [DATA_W-1:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (in_addr_lo)
            2'd0:    byte_sel = in_mem[31:24];
            2'd1:    byte_sel = in_mem[23:16];
            2'd2:    byte_sel = in_mem[15:8];
            default: byte_sel = in_mem[7:0];
        endcase

        // Halfword alignment ignores addr_lo[0]; misaligned halves are not trapped.
        half_sel = in_addr_lo[1] ? in_mem[15:0] : in_mem[31:16];

        case (in_size)
            LOAD_BYTE: load_data_o = {{24{in_signed & byte_sel[7]}}, byte_sel};
            LOAD_HALF: load_data_o = {{16{in_signed & half_sel[15]}}, half_sel};
            default:   load_data_o = in_mem;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage. Aligns/extends load data, buffers up to two pending
// register writes in a 2-entry FIFO and retires at most one per cycle onto the
// register-file write port. Outputs depend only on registered FIFO state and
// wb_hold, never combinationally on in_*.
//
// Optional feature: define WB_FWD_EN to add decode-stage bypass outputs
// (fwd_valid/fwd_rd/fwd_data mirror the write port, pend_mask flags every
// register targeted by a FIFO entry regardless of wb_hold).
//
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready       : handshake from the memory stage
//   in_reg_write            : 0 = accept and discard
//   in_rd, in_mem_to_reg, in_size, in_signed, in_addr_lo, in_alu, in_mem
//   wb_hold                 : freeze retirement
//   r_write, rd, w_data     : register-file write port
//   count                   : FIFO occupancy 0..2
// -----------------------------------------------------------------------------
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_reg_write,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_mem_to_reg,
    input  logic [1:0]           in_size,
    input  logic                 in_signed,
    input  logic [1:0]           in_addr_lo,
    input  logic [DATA_W-1:0]    in_alu,
    input  logic [DATA_W-1:0]    in_mem,
    input  logic                 wb_hold,
    output logic                 r_write,
    output logic [REG_IDX_W-1:0] rd,
    output logic [DATA_W-1:0]    w_data,
    output logic [1:0]           count
`ifdef WB_FWD_EN
    ,
    output logic                 fwd_valid,
    output logic [REG_IDX_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]    fwd_data,
    output logic [15:0]          pend_mask
`endif
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    wb_entry_t         fifo_q [DEPTH];
    logic              head_q, tail_q;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] align_data;
    logic [DATA_W-1:0] in_data;
    logic              push, pop;

    wb_load_align u_align (
        .in_mem      (in_mem),
        .in_addr_lo  (in_addr_lo),
        .in_size     (in_size),
        .in_signed   (in_signed),
        .load_data_o (align_data)
    );

    assign in_data = in_mem_to_reg ? align_data : in_alu;

    // When full but not held, the head leaves this edge, so a new entry fits.
    assign in_ready = (count_q != FULL_CNT) | ~wb_hold;
    assign pop      = (count_q != 2'd0) & ~wb_hold;
    assign push     = in_valid & in_ready & in_reg_write;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            // On push+pop while full, tail==head: the slot being vacated is
            // reused, which places the new entry behind the remaining one.
            if (push) begin
                fifo_q[tail_q] <= '{rd: in_rd, data: in_data};
                tail_q         <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign r_write = pop;
    assign rd      = pop ? fifo_q[head_q].rd   : '0;
    assign w_data  = pop ? fifo_q[head_q].data : '0;
    assign count   = count_q;

`ifdef WB_FWD_EN
    assign fwd_valid = r_write;
    assign fwd_rd    = rd;
    assign fwd_data  = w_data;

    always_comb begin
        pend_mask = 16'h0000;
        if (count_q != 2'd0) begin
            pend_mask[fifo_q[head_q].rd] = 1'b1;
        end
        if (count_q == FULL_CNT) begin
            pend_mask[fifo_q[~head_q].rd] = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_reg_write, in_mem_to_reg, in_signed, wb_hold;
    logic [3:0]  in_rd, rd;
    logic [1:0]  in_size, in_addr_lo, count;
    logic [31:0] in_alu, in_mem, w_data;
    logic        r_write;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [15:0] pend_mask;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of pending {rd, data} writes, oldest first.
    logic [35:0] mq[$];

    always #5 clk = ~clk;

    writeback_stage #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg), .in_size(in_size),
        .in_signed(in_signed), .in_addr_lo(in_addr_lo), .in_alu(in_alu),
        .in_mem(in_mem), .wb_hold(wb_hold), .r_write(r_write), .rd(rd),
        .w_data(w_data), .count(count)
`ifdef WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .pend_mask(pend_mask)
`endif
    );

    // Load extraction from arithmetic on the big-endian word.
    function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] lo);
        logic [31:0] v;
        int          bits;
        if (size[1]) return mem;
        if (size == 2'b00) begin
            bits = 8;
            v = (mem >> (8 * (3 - int'(lo)))) & 32'h0000_00FF;
        end else begin
            bits = 16;
            v = (mem >> (lo[1] ? 0 : 16)) & 32'h0000_FFFF;
        end
        if (sgn && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
        return v;
    endfunction

    task automatic set_in(input logic v, input logic rw, input logic [3:0] r, input logic m2r,
                          input logic [1:0] sz, input logic sg, input logic [1:0] lo,
                          input logic [31:0] alu, input logic [31:0] mem);
        in_valid = v; in_reg_write = rw; in_rd = r; in_mem_to_reg = m2r;
        in_size = sz; in_signed = sg; in_addr_lo = lo; in_alu = alu; in_mem = mem;
    endtask

    task automatic set_idle();
        set_in(1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    // Advance one clock; update the model from the rules using pre-edge inputs.
    task automatic advance();
        bit          do_pop, do_push;
        logic [35:0] e;
        do_pop  = (mq.size() > 0) && !wb_hold;
        do_push = in_valid && ((mq.size() < 2) || !wb_hold) && in_reg_write;
        e = {in_rd, in_mem_to_reg ? ref_load(in_mem, in_size, in_signed, in_addr_lo) : in_alu};
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        // Reset asserted from time zero.
        checks++;
        if (r_write !== 1'b0 || rd !== 4'd0 || w_data !== 32'h0 || in_ready !== 1'b1 || count !== 2'd0) begin
            failures++;
            $display("FAIL reset_init got rw=%b rd=%h wd=%h rdy=%b cnt=%0d want 0/0/0/1/0",
                     r_write, rd, w_data, in_ready, count);
        end
        @(posedge clk); #1; rst = 1'b0; #1;
        // Fill to two entries under hold, then reset mid-cycle.
        wb_hold = 1'b1;
        set_in(1'b1, 1'b1, 4'd4, 1'b0, 2'b10, 1'b0, 2'b00, 32'hAAAA_0001, 32'h0); advance();
        set_in(1'b1, 1'b1, 4'd6, 1'b0, 2'b10, 1'b0, 2'b00, 32'hAAAA_0002, 32'h0); advance();
        set_idle(); #1;
        checks++;
        if (count !== 2'd2) begin
            failures++; $display("FAIL reset_fill got cnt=%0d want 2", count);
        end
        wb_hold = 1'b0; #1;
        checks++;
        if (r_write !== 1'b1 || w_data !== 32'hAAAA_0001) begin
            failures++; $display("FAIL reset_pre got rw=%b wd=%h want 1/aaaa0001", r_write, w_data);
        end
        #2; rst = 1'b1; mq.delete(); #1;
        checks++;
        if (r_write !== 1'b0 || rd !== 4'd0 || w_data !== 32'h0 || in_ready !== 1'b1 || count !== 2'd0) begin
            failures++;
            $display("FAIL reset_async got rw=%b rd=%h wd=%h rdy=%b cnt=%0d want 0/0/0/1/0",
                     r_write, rd, w_data, in_ready, count);
        end
        @(posedge clk); #1; rst = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1 || count !== 2'd0 || r_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got rdy=%b cnt=%0d rw=%b want 1/0/0", in_ready, count, r_write);
        end
    endtask

    task automatic test_signed_byte();
        wb_hold = 1'b0;
        set_in(1'b1, 1'b1, 4'd5, 1'b1, LOAD_BYTE, 1'b1, 2'd0, 32'h0, 32'hD118_D118); #1;
        checks++;
        if (r_write !== 1'b0) begin
            failures++; $display("FAIL sbyte_latency got rw=%b want 0", r_write);
        end
        advance();
        set_in(1'b1, 1'b1, 4'd5, 1'b1, LOAD_BYTE, 1'b0, 2'd1, 32'h0, 32'hD118_D118); #1;
        checks++;
        if (r_write !== 1'b1 || rd !== 4'd5 || w_data !== 32'hFFFF_FFD1) begin
            failures++; $display("FAIL sbyte got rw=%b rd=%0d wd=%h want 1/5/ffffffd1", r_write, rd, w_data);
        end
        advance();
        set_idle(); #1;
        checks++;
        if (r_write !== 1'b1 || rd !== 4'd5 || w_data !== 32'h0000_0018) begin
            failures++; $display("FAIL ubyte got rw=%b rd=%0d wd=%h want 1/5/00000018", r_write, rd, w_data);
        end
        advance();
    endtask

    task automatic test_halfword();
        wb_hold = 1'b0;
        set_in(1'b1, 1'b1, 4'd2, 1'b1, LOAD_HALF, 1'b1, 2'b11, 32'h0, 32'h18D1_1818); advance();
        set_in(1'b1, 1'b1, 4'd2, 1'b1, LOAD_HALF, 1'b1, 2'b00, 32'h0, 32'h18D1_1818); #1;
        checks++;
        if (r_write !== 1'b1 || w_data !== 32'h0000_1818) begin
            failures++; $display("FAIL half_lo got rw=%b wd=%h want 1/00001818", r_write, w_data);
        end
        advance();
        set_idle(); #1;
        checks++;
        if (r_write !== 1'b1 || w_data !== 32'h0000_18D1) begin
            failures++; $display("FAIL half_hi got rw=%b wd=%h want 1/000018d1", r_write, w_data);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        wb_hold = 1'b1;
        set_in(1'b1, 1'b1, 4'd1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h1111_1111, 32'h0); advance();
        set_in(1'b1, 1'b1, 4'd2, 1'b0, 2'b10, 1'b0, 2'd0, 32'h2222_2222, 32'h0); advance();
        set_in(1'b1, 1'b1, 4'd3, 1'b0, 2'b10, 1'b0, 2'd0, 32'h3333_3333, 32'h0); #1;
        checks++;
        if (in_ready !== 1'b0 || count !== 2'd2 || r_write !== 1'b0) begin
            failures++; $display("FAIL bp_full got rdy=%b cnt=%0d rw=%b want 0/2/0", in_ready, count, r_write);
        end
        advance();
        checks++;
        if (count !== 2'd2) begin
            failures++; $display("FAIL bp_stall got cnt=%0d want 2", count);
        end
        wb_hold = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1 || r_write !== 1'b1 || rd !== 4'd1 || w_data !== 32'h1111_1111) begin
            failures++; $display("FAIL bp_w1 got rdy=%b rw=%b rd=%0d wd=%h want 1/1/1/11111111",
                                 in_ready, r_write, rd, w_data);
        end
        advance();
        set_idle(); #1;
        checks++;
        if (count !== 2'd2 || r_write !== 1'b1 || rd !== 4'd2 || w_data !== 32'h2222_2222) begin
            failures++; $display("FAIL bp_w2 got cnt=%0d rw=%b rd=%0d wd=%h want 2/1/2/22222222",
                                 count, r_write, rd, w_data);
        end
        advance();
        checks++;
        if (count !== 2'd1 || r_write !== 1'b1 || rd !== 4'd3 || w_data !== 32'h3333_3333) begin
            failures++; $display("FAIL bp_w3 got cnt=%0d rw=%b rd=%0d wd=%h want 1/1/3/33333333",
                                 count, r_write, rd, w_data);
        end
        advance();
        checks++;
        if (count !== 2'd0 || r_write !== 1'b0 || w_data !== 32'h0) begin
            failures++; $display("FAIL bp_empty got cnt=%0d rw=%b wd=%h want 0/0/0", count, r_write, w_data);
        end
    endtask

    task automatic test_drop_waw();
        int          writes = 0;
        logic [31:0] last = 32'h0;
        wb_hold = 1'b0;
        set_in(1'b1, 1'b0, 4'd3, 1'b0, 2'b10, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h0); advance();
        checks++;
        if (count !== 2'd0) begin
            failures++; $display("FAIL drop got cnt=%0d want 0", count);
        end
        set_in(1'b1, 1'b1, 4'd3, 1'b0, 2'b10, 1'b0, 2'd0, 32'h1, 32'h0); advance();
        set_in(1'b1, 1'b1, 4'd3, 1'b0, 2'b10, 1'b0, 2'd0, 32'h2, 32'h0); #1;
        for (int i = 0; i < 3; i++) begin
            if (r_write === 1'b1) begin
                writes++;
                checks++;
                if (rd !== 4'd3 || w_data !== 32'(writes)) begin
                    failures++; $display("FAIL waw_order got rd=%0d wd=%h want 3/%h", rd, w_data, 32'(writes));
                end
                last = w_data;
            end
            advance();
            set_idle(); #1;
        end
        checks++;
        if (writes != 2 || last !== 32'h2) begin
            failures++; $display("FAIL waw_final got writes=%0d last=%h want 2/00000002", writes, last);
        end
    endtask

`ifdef WB_FWD_EN
    task automatic test_forwarding();
        wb_hold = 1'b1;
        set_in(1'b1, 1'b1, 4'd7, 1'b0, 2'b10, 1'b0, 2'd0, 32'h7777_0000, 32'h0); advance();
        set_in(1'b1, 1'b1, 4'd9, 1'b0, 2'b10, 1'b0, 2'd0, 32'h9999_0000, 32'h0); advance();
        set_idle(); #1;
        checks++;
        if (pend_mask !== 16'h0280 || fwd_valid !== 1'b0) begin
            failures++; $display("FAIL fwd_pend got mask=%h fv=%b want 0280/0", pend_mask, fwd_valid);
        end
        wb_hold = 1'b0; #1;
        checks++;
        if (pend_mask !== 16'h0280 || fwd_valid !== 1'b1 || fwd_rd !== 4'd7 || fwd_data !== 32'h7777_0000) begin
            failures++; $display("FAIL fwd_first got mask=%h fv=%b frd=%0d fd=%h want 0280/1/7/77770000",
                                 pend_mask, fwd_valid, fwd_rd, fwd_data);
        end
        advance();
        checks++;
        if (pend_mask !== 16'h0200 || fwd_valid !== 1'b1 || fwd_rd !== 4'd9 || fwd_data !== 32'h9999_0000) begin
            failures++; $display("FAIL fwd_second got mask=%h fv=%b frd=%0d fd=%h want 0200/1/9/99990000",
                                 pend_mask, fwd_valid, fwd_rd, fwd_data);
        end
        advance();
    endtask
`endif

    task automatic test_random();
        bit          e_rw;
        logic [3:0]  e_rd;
        logic [31:0] e_wd;
        logic [15:0] e_mask;
        for (int i = 0; i < 400; i++) begin
            wb_hold = ($urandom_range(0, 9) < 3);
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), 4'($urandom),
                   1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom);
            #1;
            e_rw = (mq.size() > 0) && !wb_hold;
            e_rd = e_rw ? mq[0][35:32] : 4'd0;
            e_wd = e_rw ? mq[0][31:0]  : 32'h0;
            e_mask = 16'h0;
            foreach (mq[k]) e_mask[mq[k][35:32]] = 1'b1;
            checks++;
            if (r_write !== e_rw || rd !== e_rd || w_data !== e_wd || count !== 2'(mq.size())
                || in_ready !== ((mq.size() < 2) || !wb_hold)) begin
                failures++;
                $display("FAIL rand[%0d] got rw=%b rd=%0d wd=%h cnt=%0d rdy=%b want rw=%b rd=%0d wd=%h cnt=%0d",
                         i, r_write, rd, w_data, count, in_ready, e_rw, e_rd, e_wd, mq.size());
            end
`ifdef WB_FWD_EN
            checks++;
            if (pend_mask !== e_mask || fwd_valid !== e_rw || fwd_rd !== e_rd || fwd_data !== e_wd) begin
                failures++;
                $display("FAIL rand_fwd[%0d] got mask=%h fv=%b want mask=%h fv=%b", i, pend_mask, fwd_valid, e_mask, e_rw);
            end
`endif
            advance();
        end
        wb_hold = 1'b0;
        set_idle();
        advance(); advance();
    endtask

    initial begin
        rst = 1'b1;
        wb_hold = 1'b0;
        set_idle();
        #1;
        test_reset();
        test_signed_byte();
        test_halfword();
        test_back_to_back();
        test_drop_waw();
`ifdef WB_FWD_EN
        test_forwarding();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
